vsrc_real_nco: RTL and testbench
================================

Name: vsrc_real_nco

Overview:
- Clocked, parametrised successor to the free-running PWC sine stimulus source.
- A phase accumulator (NCO) drives a differential real-valued output pair. Four waveform modes are supported.
- Adds burst-count operation, a start/done control FSM, and phase-continuous parameter reload via a load/ack handshake.
- Used in testbenches to drive real-number analog models from a digital clock domain.

Parameters:
- ACC_W, 24, phase accumulator width in bits; one period = 2^ACC_W phase units.
- BURST_W, 16, width of the burst period counter.
- FCW0, 0, fcw value loaded into the active register at reset.

Ports:
- clk  input  1  sampling clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request to begin generation.
- en  input  1  run enable; low freezes generation.
- load  input  1  request to transfer shadow inputs to active registers; held until load_ack.
- load_ack  output  1  single-cycle pulse when the transfer happens.
- mode  input  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
- fcw  input  ACC_W  frequency control word; f = fcw*fclk/2^ACC_W.
- phase_ofs  input  ACC_W  phase offset added to the accumulator.
- amp  input  real  amplitude.
- dc  input  real  dc offset.
- burst_len  input  BURST_W  number of full periods; 0 = continuous.
- busy  output  1  high in RUN.
- done  output  1  single-cycle pulse when a burst completes.
- wrap  output  1  single-cycle pulse on accumulator carry-out.
- vout  output  real  dc + amp*w.
- voutb  output  real  dc - amp*w.

Behaviour:
- Reset (async):
  - acc = 0, state IDLE, period counter = 0.
  - Active regs: mode = 0, fcw = FCW0, phase_ofs = 0, amp = 0.0, dc = 0.0.
  - Outputs: vout = voutb = 0.0; busy, done, wrap, load_ack = 0.
- Waveform value: p = (acc + phase_ofs) mod 2^ACC_W, u = p/2^ACC_W.
  - sine: w = sin(2*pi*u).
  - square: w = +1 if u < 0.5, else -1.
  - triangle: w = 4u-1 if u < 0.5, else 3-4u.
  - sawtooth: w = 2u-1.
- FSM states:
  - IDLE: w = 0, so vout = voutb = dc_active; acc held. start -> RUN with acc cleared to 0 and counter cleared.
  - RUN: while en = 1, each cycle acc <= acc + fcw (mod 2^ACC_W).
    - Carry-out asserts wrap in the same cycle the new acc is registered, and increments the counter.
    - While en = 0, acc, counter and outputs hold; wrap cannot assert.
    - If burst_len != 0 and the counter reaches burst_len on a wrap -> DONE.
    - start while in RUN is ignored.
  - DONE: for one cycle, done = 1, busy = 0, w = 0; then -> IDLE.
- Output latency: vout/voutb are registered from the current acc.
  - First RUN cycle outputs w at p = phase_ofs.
  - Each subsequent output reflects the acc value after that cycle's add.
- burst_len is sampled on start; changes during RUN have no effect.
- Load handshake:
  - In IDLE or DONE: load applies mode/fcw/phase_ofs/amp/dc on the next edge, with load_ack = 1 that cycle.
  - In RUN: transfer is deferred to the cycle a wrap occurs (phase-continuous), with load_ack = 1 in that cycle. The new values take effect from the next output sample.
  - load deasserted before ack cancels the request.
- Simultaneous events:
  - load + start in IDLE: load applied in the same edge; RUN uses the new values.
  - Wrap that completes a burst with load pending: the load is applied and acked; state -> DONE.
- fcw = 0 in RUN: output constant, no wraps; a nonzero burst never completes. This is legal; the bench must avoid it or reset.
- rst mid-RUN: immediate return to reset values; no done pulse.

Test Plan:
- ACC_W=8, fcw=16, mode=3, amp=1.0, dc=0.5, burst_len=2, start:
  - vout steps -0.5, -0.375, ... by 0.125 per cycle.
  - wrap at cycles 16 and 32; done at cycle 33, then outputs 0.5.
- Same setup, mode=1, burst_len=0: vout alternates 1.5 for 8 cycles and -0.5 for 8 cycles indefinitely; busy stays 1.
- RUN with fcw=16; load with fcw=32 at cycle 5: load_ack only at cycle-16 wrap; next period lasts 8 cycles; no phase discontinuity.
- en low for 10 cycles mid-RUN: vout, acc and wrap frozen; generation resumes exactly where it left off.
- mode=0, phase_ofs=64 (ACC_W=8), amp=2.0, dc=0.0: first RUN sample vout = 2.0, voutb = -2.0.
- rst asserted asynchronously mid-RUN: outputs 0.0 and busy 0 without waiting for a clk edge; no done pulse.

Source files
------------

// File: rtl/vsrc_real_nco.sv
// vsrc_real_nco: clocked NCO stimulus source driving a differential real pair.
//
// A phase accumulator advances by fcw each enabled RUN cycle. The phase
// (acc + phase_ofs) selects a sine, square, triangle or sawtooth value w,
// and the outputs are vout = dc + amp*w, voutb = dc - amp*w. Burst mode stops
// after burst_len full periods. Shadow parameters are moved to the active
// registers through a load/ack handshake. While running, that transfer waits
// for a wrap so the phase stays continuous.
//
// Ports:
//   clk, rst        sampling clock, asynchronous active-high reset
//   start           single-cycle request to begin generation
//   en              run enable; low freezes acc, counter and outputs
//   load / load_ack shadow-to-active transfer request and its one-cycle ack
//   mode            0 sine, 1 square, 2 triangle, 3 sawtooth
//   fcw, phase_ofs  frequency control word, phase offset (ACC_W bits)
//   amp, dc         amplitude and dc offset (real)
//   burst_len       periods per burst, 0 = continuous (sampled on start)
//   busy, done      running flag, one-cycle burst-complete pulse
//   wrap            one-cycle pulse on accumulator carry-out
//   vout, voutb     differential real outputs
//
// state   | meaning
// --------+-----------------------------------------------------------
// st_idle | waiting for start; w = 0, outputs sit at dc; loads apply at once
// st_run  | accumulating while en; loads wait for a wrap
// st_done | one cycle after the final wrap; produces the done pulse
//
// Outputs are registered. They show the state that was current at the
// previous edge, so done appears in the cycle after the final wrap.
module vsrc_real_nco #(
  parameter int              ACC_W   = 24,
  parameter int              BURST_W = 16,
  parameter logic [ACC_W-1:0] FCW0   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               en,
  input  logic               load,
  output logic               load_ack,
  input  logic [1:0]         mode,
  input  logic [ACC_W-1:0]   fcw,
  input  logic [ACC_W-1:0]   phase_ofs,
  input  real                amp,
  input  real                dc,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output real                vout,
  output real                voutb
);

  typedef enum logic [1:0] {st_idle, st_run, st_done} state_t;

  state_t state, state_n;

  logic [ACC_W-1:0]   acc, acc_n;
  logic [BURST_W-1:0] cnt, cnt_n, cnt_inc;
  logic [BURST_W-1:0] burst_q, burst_n;

  logic [1:0]         mode_q;
  logic [ACC_W-1:0]   fcw_q, ofs_q;
  real                amp_q, dc_q;

  logic [ACC_W:0]     sum;
  logic               carry;
  logic               do_load;

  // Parameter set used for this edge's output sample. In idle and done a
  // load takes effect immediately. In run the sample still uses the old set.
  logic [1:0]         mode_s;
  logic [ACC_W-1:0]   ofs_s, acc_s, p_s;
  real                amp_s, dc_s, w_n;
  logic               busy_n, done_n, wrap_n;

  function automatic real wave(input logic [1:0] m, input logic [ACC_W-1:0] p);
    real u;
    real r;
    u = real'(p) / (2.0 ** ACC_W);
    r = 0.0;
    case (m)
      2'd0: r = $sin(6.283185307179586 * u);
      2'd1: r = p[ACC_W-1] ? -1.0 : 1.0;
      2'd2: r = (u < 0.5) ? (4.0 * u - 1.0) : (3.0 - 4.0 * u);
      default: r = 2.0 * u - 1.0;
    endcase
    return r;
  endfunction

  assign sum     = {1'b0, acc} + {1'b0, fcw_q};
  assign carry   = sum[ACC_W];
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= st_idle;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    burst_n = burst_q;
    do_load = 1'b0;
    acc_s   = acc;
    w_n     = 0.0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    wrap_n  = 1'b0;

    case (state)
      st_idle: begin
        do_load = load;
        if (start) begin
          state_n = st_run;
          acc_n   = '0;
          cnt_n   = '0;
          burst_n = burst_len;
          busy_n  = 1'b1;
        end
      end
      st_run: begin
        busy_n = 1'b1;
        if (en) begin
          acc_n  = sum[ACC_W-1:0];
          acc_s  = sum[ACC_W-1:0];
          wrap_n = carry;
          if (carry) begin
            do_load = load;
            cnt_n   = cnt_inc;
            if (burst_q != '0 && cnt_inc == burst_q) state_n = st_done;
          end
        end
      end
      default: begin
        do_load = load;
        done_n  = 1'b1;
        state_n = st_idle;
      end
    endcase

    if (do_load && state != st_run) begin
      mode_s = mode;
      ofs_s  = phase_ofs;
      amp_s  = amp;
      dc_s   = dc;
    end else begin
      mode_s = mode_q;
      ofs_s  = ofs_q;
      amp_s  = amp_q;
      dc_s   = dc_q;
    end

    if (state == st_idle && start) acc_s = '0;
    p_s = acc_s + ofs_s;

    // A sample is produced for the start edge and for every run edge. When
    // en is low the recomputed sample equals the held one.
    if ((state == st_idle && start) || state == st_run) w_n = wave(mode_s, p_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      burst_q  <= '0;
      mode_q   <= 2'd0;
      fcw_q    <= FCW0;
      ofs_q    <= '0;
      amp_q    <= 0.0;
      dc_q     <= 0.0;
      vout     <= 0.0;
      voutb    <= 0.0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      acc      <= acc_n;
      cnt      <= cnt_n;
      burst_q  <= burst_n;
      if (do_load) begin
        mode_q <= mode;
        fcw_q  <= fcw;
        ofs_q  <= phase_ofs;
        amp_q  <= amp;
        dc_q   <= dc;
      end
      vout     <= dc_s + amp_s * w_n;
      voutb    <= dc_s - amp_s * w_n;
      busy     <= busy_n;
      done     <= done_n;
      wrap     <= wrap_n;
      load_ack <= do_load;
    end
  end

endmodule

// File: tb/tb_vsrc_real_nco.sv
// Directed bench for vsrc_real_nco at ACC_W = 8 (one period = 256 units).
// Inputs change 1 ns after a rising edge, and outputs are sampled there too.
// P_k is the cycle after the k-th edge following the edge that sampled start.
module tb_vsrc_real_nco;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic        load_ack;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  fcw = 8'd0;
  logic [7:0]  phase_ofs = 8'd0;
  real         amp = 0.0;
  real         dc = 0.0;
  logic [15:0] burst_len = 16'd0;
  logic        busy, done, wrap;
  real         vout, voutb;

  int n_tests = 0;
  int n_fail  = 0;

  vsrc_real_nco #(.ACC_W(8), .BURST_W(16), .FCW0(8'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .load(load),
    .load_ack(load_ack), .mode(mode), .fcw(fcw), .phase_ofs(phase_ofs),
    .amp(amp), .dc(dc), .burst_len(burst_len), .busy(busy), .done(done),
    .wrap(wrap), .vout(vout), .voutb(voutb)
  );

  always #5 clk = ~clk;

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [1:0] m, input logic [7:0] f, input logic [7:0] o,
                       input real a, input real d, input logic [15:0] bl);
    mode = m; fcw = f; phase_ofs = o; amp = a; dc = d; burst_len = bl; en = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (vout != 0.0) begin n_fail++; $display("FAIL reset_vout got %f want 0.0", vout); end
    n_tests++; if (voutb != 0.0) begin n_fail++; $display("FAIL reset_voutb got %f want 0.0", voutb); end
    n_tests++; if ({busy, done, wrap, load_ack} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags got %b want 0000", {busy, done, wrap, load_ack}); end
    cycle();
    rst = 1'b0;
    cycle();
    n_tests++; if (vout != 0.0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL idle_after_reset vout %f busy %b want 0.0 0", vout, busy); end
  endtask

  task automatic test_idle_load();
    setup(2'd3, 8'd16, 8'd0, 1.0, 0.5, 16'd2);
    load = 1'b1;
    cycle();
    load = 1'b0;
    n_tests++; if (load_ack !== 1'b1) begin n_fail++; $display("FAIL idle_load_ack got %b want 1", load_ack); end
    n_tests++; if (vout != 0.5 || voutb != 0.5) begin n_fail++;
      $display("FAIL idle_dc got %f/%f want 0.5/0.5", vout, voutb); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    cycle();
    n_tests++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack_pulse got %b want 0", load_ack); end
  endtask

  // Sawtooth, burst of 2: wraps at P_16 and P_32, done at P_33.
  task automatic test_saw_burst();
    real ev, evb;
    setup(2'd3, 8'd16, 8'd0, 1.0, 0.5, 16'd2);
    start = 1'b1; load = 1'b1;
    cycle();
    start = 1'b0; load = 1'b0;
    n_tests++; if (load_ack !== 1'b1 || busy !== 1'b1) begin n_fail++;
      $display("FAIL saw_start ack %b busy %b want 1 1", load_ack, busy); end
    n_tests++; if (vout != -0.5) begin n_fail++; $display("FAIL saw_first got %f want -0.5", vout); end
    for (int k = 1; k <= 32; k++) begin
      if (k == 3) burst_len = 16'd7;
      if (k == 5) start = 1'b1;
      cycle();
      start = 1'b0;
      ev  = -0.5 + 0.125 * (k % 16);
      evb = 1.5 - 0.125 * (k % 16);
      n_tests++; if (vout != ev || voutb != evb) begin n_fail++;
        $display("FAIL saw_k%0d got %f/%f want %f/%f", k, vout, voutb, ev, evb); end
      n_tests++; if (wrap !== (k == 16 || k == 32)) begin n_fail++;
        $display("FAIL saw_wrap_k%0d got %b want %b", k, wrap, (k == 16 || k == 32)); end
      n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++;
        $display("FAIL saw_busy_k%0d busy %b done %b want 1 0", k, busy, done); end
    end
    burst_len = 16'd2;
    cycle();
    n_tests++; if (done !== 1'b1 || busy !== 1'b0 || wrap !== 1'b0) begin n_fail++;
      $display("FAIL saw_done done %b busy %b wrap %b want 1 0 0", done, busy, wrap); end
    n_tests++; if (vout != 0.5 || voutb != 0.5) begin n_fail++;
      $display("FAIL saw_done_out got %f/%f want 0.5/0.5", vout, voutb); end
    cycle();
    n_tests++; if (done !== 1'b0 || vout != 0.5) begin n_fail++;
      $display("FAIL saw_after_done done %b vout %f want 0 0.5", done, vout); end
  endtask

  task automatic test_square_continuous();
    real ev;
    setup(2'd1, 8'd16, 8'd0, 1.0, 0.5, 16'd0);
    start = 1'b1; load = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (k == 0) begin start = 1'b0; load = 1'b0; end
      ev = ((k % 16) < 8) ? 1.5 : -0.5;
      n_tests++; if (vout != ev || voutb != (1.0 - ev)) begin n_fail++;
        $display("FAIL sq_k%0d got %f/%f want %f/%f", k, vout, voutb, ev, 1.0 - ev); end
      n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++;
        $display("FAIL sq_busy_k%0d busy %b done %b want 1 0", k, busy, done); end
    end
  endtask

  // Called while the square wave is still running.
  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    n_tests++; if (vout != 0.0 || voutb != 0.0) begin n_fail++;
      $display("FAIL arst_out got %f/%f want 0.0/0.0", vout, voutb); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_tests++; if (done !== 1'b0 || busy !== 1'b0 || vout != 0.0) begin n_fail++;
        $display("FAIL arst_after_k%0d done %b busy %b vout %f want 0 0 0.0", k, done, busy, vout); end
    end
  endtask

  // fcw 16 -> 32 requested at P_5; applied at the P_16 wrap.
  task automatic test_reload();
    int  a;
    real ev;
    setup(2'd3, 8'd16, 8'd0, 1.0, 0.5, 16'd0);
    start = 1'b1; load = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      cycle();
      if (k == 0) begin start = 1'b0; load = 1'b0; end
      a  = (k <= 16) ? (16 * k) % 256 : (32 * (k - 16)) % 256;
      ev = -0.5 + 2.0 * a / 256.0;
      n_tests++; if (vout != ev) begin n_fail++; $display("FAIL rl_k%0d got %f want %f", k, vout, ev); end
      if (k > 0) begin
        n_tests++; if (load_ack !== (k == 16)) begin n_fail++;
          $display("FAIL rl_ack_k%0d got %b want %b", k, load_ack, (k == 16)); end
        n_tests++; if (wrap !== (k == 16 || k == 24 || k == 32)) begin n_fail++;
          $display("FAIL rl_wrap_k%0d got %b want %b", k, wrap, (k == 16 || k == 24 || k == 32)); end
      end
      if (k == 5) begin fcw = 8'd32; load = 1'b1; end
      if (k == 16) load = 1'b0;
    end
    fcw = 8'd16;
    pulse_reset();
  endtask

  // en low over P_16..P_25, just before a wrap. A load raised and then
  // dropped before any wrap is cancelled.
  task automatic test_en_freeze();
    int  a;
    real ev;
    setup(2'd3, 8'd16, 8'd0, 1.0, 0.5, 16'd0);
    start = 1'b1; load = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      cycle();
      if (k == 0) begin start = 1'b0; load = 1'b0; end
      a  = (k <= 15) ? 16 * k : (k <= 25) ? 240 : (16 * (k - 10)) % 256;
      ev = -0.5 + 2.0 * a / 256.0;
      n_tests++; if (vout != ev) begin n_fail++; $display("FAIL en_k%0d got %f want %f", k, vout, ev); end
      n_tests++; if (wrap !== (k == 26)) begin n_fail++;
        $display("FAIL en_wrap_k%0d got %b want %b", k, wrap, (k == 26)); end
      n_tests++; if (load_ack !== (k == 0) || busy !== 1'b1) begin n_fail++;
        $display("FAIL en_ack_k%0d ack %b busy %b want %b 1", k, load_ack, busy, (k == 0)); end
      if (k == 3) begin fcw = 8'd64; load = 1'b1; end
      if (k == 6) begin fcw = 8'd16; load = 1'b0; end
      if (k == 15) en = 1'b0;
      if (k == 25) en = 1'b1;
    end
    pulse_reset();
  endtask

  task automatic test_sine_phase();
    setup(2'd0, 8'd16, 8'd64, 2.0, 0.0, 16'd0);
    start = 1'b1; load = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      cycle();
      if (k == 0) begin start = 1'b0; load = 1'b0; end
      if (k == 0) begin
        n_tests++; if (rabs(vout - 2.0) > 1e-9 || rabs(voutb + 2.0) > 1e-9) begin n_fail++;
          $display("FAIL sine_first got %f/%f want 2.0/-2.0", vout, voutb); end
      end
      if (k == 4) begin
        n_tests++; if (rabs(vout) > 1e-9) begin n_fail++; $display("FAIL sine_half got %f want 0.0", vout); end
      end
      if (k == 8) begin
        n_tests++; if (rabs(vout + 2.0) > 1e-9) begin n_fail++; $display("FAIL sine_3q got %f want -2.0", vout); end
      end
    end
    pulse_reset();
  endtask

  // Burst of 1 whose completing wrap also takes a pending load.
  task automatic test_burst_load_done();
    setup(2'd3, 8'd16, 8'd0, 1.0, 0.5, 16'd1);
    start = 1'b1; load = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      cycle();
      if (k == 0) begin start = 1'b0; load = 1'b0; end
      if (k > 10 && k < 16) begin
        n_tests++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL bl_early_ack_k%0d got %b want 0", k, load_ack); end
      end
      if (k == 16) begin
        n_tests++; if ({wrap, load_ack, busy, done} !== 4'b1110) begin n_fail++;
          $display("FAIL bl_wrap got %b want 1110", {wrap, load_ack, busy, done}); end
        n_tests++; if (vout != -0.5) begin n_fail++; $display("FAIL bl_wrap_out got %f want -0.5", vout); end
      end
      if (k == 17) begin
        n_tests++; if ({done, busy, load_ack} !== 3'b100) begin n_fail++;
          $display("FAIL bl_done got %b want 100", {done, busy, load_ack}); end
        n_tests++; if (vout != 0.25 || voutb != 0.25) begin n_fail++;
          $display("FAIL bl_done_out got %f/%f want 0.25/0.25", vout, voutb); end
      end
      if (k == 18) begin
        n_tests++; if (done !== 1'b0 || busy !== 1'b0 || vout != 0.25) begin n_fail++;
          $display("FAIL bl_idle done %b busy %b vout %f want 0 0 0.25", done, busy, vout); end
      end
      if (k == 10) begin fcw = 8'd32; dc = 0.25; load = 1'b1; end
      if (k == 16) load = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_saw_burst();
    test_square_continuous();
    test_async_reset();
    test_reload();
    test_en_freeze();
    test_sine_phase();
    test_burst_load_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
